// File: rtl/multi_seat_call_controller.sv
// Multi-seat attendant call controller: per-seat call/ack FSMs, lowest-index call reporting, chime and escalation.
// Optional CALL_BLINK_EN macro: ACKED lights blink from a shared BLINK_HALF divider.
module multi_seat_call_controller #(
  parameter int NUM_SEATS    = 8,
  parameter int SEAT_W       = 3,
  parameter int ESC_CYCLES   = 1000,
  parameter int CHIME_CYCLES = 4,
  parameter int BLINK_HALF   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SEATS-1:0] call_button,
  input  logic [NUM_SEATS-1:0] cancel_button,
  input  logic                 ack,
  output logic [NUM_SEATS-1:0] light_state,
  output logic                 active_valid,
  output logic [SEAT_W-1:0]    active_seat,
  output logic                 any_call,
  output logic                 chime,
  output logic                 escalate
);

  localparam int CHW = $clog2(CHIME_CYCLES + 1);
  localparam int ESW = $clog2(ESC_CYCLES + 1);

  if ((1 << SEAT_W) < NUM_SEATS) begin : g_bad_seat_w
    $error("SEAT_W too narrow for NUM_SEATS");
  end
  if (BLINK_HALF < 1) begin : g_bad_blink
    $error("BLINK_HALF must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_CALLED, S_ACKED} seat_t;

  seat_t                st     [NUM_SEATS];
  seat_t                st_nxt [NUM_SEATS];
  logic [CHW-1:0]       chime_cnt, chime_nxt;
  logic [ESW-1:0]       esc_cnt, esc_nxt;
  logic                 ack_hit, enter_called, any_called;
  logic                 sel_valid;
  logic [SEAT_W-1:0]    sel_seat;
  logic [NUM_SEATS-1:0] busy_nxt, light_nxt;

`ifdef CALL_BLINK_EN
  localparam int BKW = $clog2(BLINK_HALF + 1);
  logic [BKW-1:0] blink_cnt, blink_cnt_nxt;
  logic           blink_phase, blink_phase_nxt;

  always_comb begin
    blink_cnt_nxt   = blink_cnt + BKW'(1);
    blink_phase_nxt = blink_phase;
    if (blink_cnt == BKW'(BLINK_HALF - 1)) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = ~blink_phase;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;
    end
  end
`endif

  always_comb begin
    ack_hit      = ack && active_valid && (st[active_seat] == S_CALLED);
    enter_called = 1'b0;
    any_called   = 1'b0;
    sel_valid    = 1'b0;
    sel_seat     = '0;
    busy_nxt     = '0;
    light_nxt    = '0;
    for (int unsigned i = 0; i < NUM_SEATS; i++) begin
      st_nxt[i] = st[i];
      unique case (st[i])
        S_IDLE:   if (call_button[i]) st_nxt[i] = S_CALLED;
        // cancel outranks ack, ack outranks a simultaneous call
        S_CALLED: begin
          if (cancel_button[i] && !call_button[i])      st_nxt[i] = S_IDLE;
          else if (ack_hit && active_seat == SEAT_W'(i)) st_nxt[i] = S_ACKED;
        end
        S_ACKED: begin
          if (cancel_button[i] && !call_button[i]) st_nxt[i] = S_IDLE;
          else if (call_button[i])                 st_nxt[i] = S_CALLED;
        end
        default:  st_nxt[i] = S_IDLE;
      endcase
      if (st_nxt[i] == S_CALLED && st[i] != S_CALLED) enter_called = 1'b1;
      if (st[i] == S_CALLED) begin
        any_called = 1'b1;
        if (!sel_valid) begin
          sel_valid = 1'b1;
          sel_seat  = SEAT_W'(i);
        end
      end
      busy_nxt[i] = (st_nxt[i] != S_IDLE);
`ifdef CALL_BLINK_EN
      light_nxt[i] = (st_nxt[i] == S_CALLED) || (st_nxt[i] == S_ACKED && blink_phase_nxt);
`else
      light_nxt[i] = busy_nxt[i];
`endif
    end

    if (enter_called)            chime_nxt = CHW'(CHIME_CYCLES);
    else if (chime_cnt != '0)    chime_nxt = chime_cnt - CHW'(1);
    else                         chime_nxt = chime_cnt;

    if (ack_hit || !any_called)             esc_nxt = '0;
    else if (esc_cnt != ESW'(ESC_CYCLES))   esc_nxt = esc_cnt + ESW'(1);
    else                                    esc_nxt = esc_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SEATS; i++) st[i] <= S_IDLE;
      chime_cnt    <= '0;
      esc_cnt      <= '0;
      light_state  <= '0;
      active_valid <= 1'b0;
      active_seat  <= '0;
      any_call     <= 1'b0;
      chime        <= 1'b0;
      escalate     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_SEATS; i++) st[i] <= st_nxt[i];
      chime_cnt    <= chime_nxt;
      esc_cnt      <= esc_nxt;
      light_state  <= light_nxt;
      active_valid <= sel_valid;
      active_seat  <= sel_seat;
      any_call     <= |busy_nxt;
      chime        <= (chime_nxt != '0);
      escalate     <= (esc_nxt == ESW'(ESC_CYCLES));
    end
  end

endmodule

// File: tb/tb_multi_seat_call_controller.sv
// Bench for multi_seat_call_controller: directed vector table, escalation sequence, random run against a reference model.
module tb_multi_seat_call_controller;

  localparam int NS  = 4;
  localparam int ESC = 8;
  localparam int CHM = 4;

  logic          clk;
  logic          rst_n;
  logic [NS-1:0] call_button, cancel_button;
  logic          ack;
  logic [NS-1:0] light_state;
  logic          active_valid;
  logic [1:0]    active_seat;
  logic          any_call, chime, escalate;

  int n_checks = 0;
  int n_fail   = 0;

  multi_seat_call_controller #(
    .NUM_SEATS(NS), .SEAT_W(2), .ESC_CYCLES(ESC), .CHIME_CYCLES(CHM), .BLINK_HALF(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .call_button(call_button), .cancel_button(cancel_button),
    .ack(ack), .light_state(light_state), .active_valid(active_valid),
    .active_seat(active_seat), .any_call(any_call), .chime(chime), .escalate(escalate)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Reference model: seat states 0=idle 1=called 2=acked, plus plain integer counters.
  int m_st[NS];
  int m_av, m_as, m_ch, m_esc;

  task automatic model_step(input logic r, input logic [NS-1:0] c, input logic [NS-1:0] x, input logic a);
    int  old[NS];
    int  old_as;
    bit  acc, entered;
    old    = m_st;
    old_as = m_as;
    if (!r) begin
      foreach (m_st[i]) m_st[i] = 0;
      m_av = 0; m_as = 0; m_ch = 0; m_esc = 0;
      return;
    end
    acc     = a && (m_av == 1) && (old[old_as] == 1);
    entered = 0;
    for (int i = 0; i < NS; i++) begin
      if (old[i] == 0 && c[i])                          m_st[i] = 1;
      else if (old[i] != 0 && x[i] && !c[i])            m_st[i] = 0;
      else if (old[i] == 1 && acc && old_as == i)       m_st[i] = 2;
      else if (old[i] == 2 && c[i])                     m_st[i] = 1;
      if (m_st[i] == 1 && old[i] != 1) entered = 1;
    end
    m_av = 0; m_as = 0;
    for (int i = NS - 1; i >= 0; i--)
      if (old[i] == 1) begin m_av = 1; m_as = i; end
    m_ch  = entered ? CHM : (m_ch > 0 ? m_ch - 1 : 0);
    m_esc = (acc || m_av == 0) ? 0 : (m_esc < ESC ? m_esc + 1 : ESC);
  endtask

  function automatic logic [NS-1:0] model_light();
    logic [NS-1:0] l;
    for (int i = 0; i < NS; i++) l[i] = (m_st[i] != 0);
    return l;
  endfunction

  task automatic compare_model(input int cyc);
    chk("rnd_light",  cyc, 8'(light_state),  8'(model_light()));
    chk("rnd_avalid", cyc, 8'(active_valid), 8'(m_av));
    chk("rnd_aseat",  cyc, 8'(active_seat),  8'(m_as));
    chk("rnd_any",    cyc, 8'(any_call),     8'(|model_light()));
    chk("rnd_chime",  cyc, 8'(chime),        8'(m_ch > 0));
    chk("rnd_esc",    cyc, 8'(escalate),     8'(m_esc == ESC));
  endtask

  task automatic drive(input logic r, input logic [NS-1:0] c, input logic [NS-1:0] x, input logic a);
    rst_n = r; call_button = c; cancel_button = x; ack = a;
    @(posedge clk);
    #1;
    model_step(r, c, x, a);
  endtask

  typedef struct {
    logic r; logic [3:0] c; logic [3:0] x; logic a;
    logic [3:0] lt; logic av; logic [1:0] as; logic any; logic ch; logic esc;
  } vec_t;

  vec_t tbl[22];

  initial begin
    rst_n = 1'b0; call_button = '0; cancel_button = '0; ack = 1'b0;

    //           r   call     cancel   ack   light   av  as  any ch  esc
    tbl[0]  = '{0, 4'b1111, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 4'b1111, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 4'b0100, 4'b0000, 0, 4'b0100, 0, 0, 1, 1, 0};
    tbl[5]  = '{1, 4'b0000, 4'b0000, 0, 4'b0100, 1, 2, 1, 1, 0};
    tbl[6]  = '{1, 4'b0000, 4'b0000, 0, 4'b0100, 1, 2, 1, 1, 0};
    tbl[7]  = '{1, 4'b0000, 4'b0000, 0, 4'b0100, 1, 2, 1, 1, 0};
    tbl[8]  = '{1, 4'b0000, 4'b0000, 0, 4'b0100, 1, 2, 1, 0, 0};
    tbl[9]  = '{1, 4'b0000, 4'b0100, 0, 4'b0000, 1, 2, 0, 0, 0};
    tbl[10] = '{1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0};
    tbl[11] = '{1, 4'b1010, 4'b0000, 0, 4'b1010, 0, 0, 1, 1, 0};
    tbl[12] = '{1, 4'b0000, 4'b0000, 0, 4'b1010, 1, 1, 1, 1, 0};
    tbl[13] = '{1, 4'b0000, 4'b0000, 1, 4'b1010, 1, 1, 1, 1, 0};
    tbl[14] = '{1, 4'b0000, 4'b0000, 0, 4'b1010, 1, 3, 1, 1, 0};
    tbl[15] = '{1, 4'b0000, 4'b0000, 1, 4'b1010, 1, 3, 1, 0, 0};
    tbl[16] = '{1, 4'b0000, 4'b0000, 0, 4'b1010, 0, 0, 1, 0, 0};
    tbl[17] = '{1, 4'b0001, 4'b0001, 0, 4'b1011, 0, 0, 1, 1, 0};
    tbl[18] = '{1, 4'b0000, 4'b0000, 0, 4'b1011, 1, 0, 1, 1, 0};
    tbl[19] = '{1, 4'b0000, 4'b0001, 1, 4'b1010, 1, 0, 1, 1, 0};
    tbl[20] = '{1, 4'b0000, 4'b0000, 0, 4'b1010, 0, 0, 1, 1, 0};
    tbl[21] = '{1, 4'b0000, 4'b1010, 0, 4'b0000, 0, 0, 0, 0, 0};

    for (int k = 0; k < 22; k++) begin
      drive(tbl[k].r, tbl[k].c, tbl[k].x, tbl[k].a);
      chk("vec_light",  k, 8'(light_state),  8'(tbl[k].lt));
      chk("vec_avalid", k, 8'(active_valid), 8'(tbl[k].av));
      chk("vec_aseat",  k, 8'(active_seat),  8'(tbl[k].as));
      chk("vec_any",    k, 8'(any_call),     8'(tbl[k].any));
      chk("vec_chime",  k, 8'(chime),        8'(tbl[k].ch));
      chk("vec_esc",    k, 8'(escalate),     8'(tbl[k].esc));
    end

    // Escalation: alarm exactly ESC cycles after the light rises, cleared by ack, re-armed by re-call.
    begin
      int wait_n;
      drive(1, 4'b0001, 4'b0000, 0);
      chk("esc_light_rise", 0, 8'(light_state[0]), 8'd1);
      chk("esc_low_at_call", 0, 8'(escalate), 8'd0);
      wait_n = 0;
      while (!escalate && wait_n < 20) begin
        drive(1, 4'b0000, 4'b0000, 0);
        wait_n++;
      end
      chk("esc_delay", 0, 8'(wait_n), 8'(ESC));
      drive(1, 4'b0000, 4'b0000, 1);
      chk("esc_ack_clear", 0, 8'(escalate), 8'd0);
      chk("esc_ack_light", 0, 8'(light_state[0]), 8'd1);
      drive(1, 4'b0000, 4'b0000, 0);
      chk("esc_acked_chime_idle", 0, 8'(chime), 8'd0);
      drive(1, 4'b0001, 4'b0000, 0);
      chk("recall_chime", 0, 8'(chime), 8'd1);
      for (int n = 1; n <= ESC; n++) begin
        drive(1, 4'b0000, 4'b0000, 0);
        chk("recall_esc", n, 8'(escalate), 8'(n == ESC));
      end
      drive(1, 4'b0000, 4'b0001, 0);
      chk("esc_cancel_light", 0, 8'(light_state), 8'd0);
      drive(1, 4'b0000, 4'b0000, 0);
      chk("esc_cancel_drop", 0, 8'(escalate), 8'd0);
    end

    // Random traffic against the reference model, with occasional mid-run resets.
    drive(0, 4'b0000, 4'b0000, 0);
    drive(0, 4'b0000, 4'b0000, 0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [NS-1:0] c, x;
      logic r, a;
      for (int i = 0; i < NS; i++) begin
        c[i] = ($urandom_range(0, 9) == 0);
        x[i] = ($urandom_range(0, 7) == 0);
      end
      a = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 299) != 0);
      drive(r, c, x, a);
      compare_model(cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
